instr_fetch: RTL and testbench

- Instruction fetch stage of the 8-bit pipeline. It sits directly upstream of the IF/ID register.
- Holds the PC and a writable instruction memory, and presents the instruction at the PC each cycle.
- Pre-decodes the 2-bit opcode into the regwrite and wbsel controls that the IF/ID register latches.
- Handles a run/halt state machine, jumps, stalls and program loading.

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage of the 8-bit pipeline, sitting directly upstream of
//   the IF/ID register. Holds the PC and a writable instruction memory,
//   presents imem[pc] each RUN cycle, and pre-decodes the 2-bit opcode into
//   regwrite / wbsel. A small IDLE / RUN / HALTED state machine controls
//   execution; jumps, stalls and program loading are handled here.
//
//   Parameters
//     IMEM_DEPTH  number of 8-bit instruction words (power of two, 2..64)
//     PC_W        PC width, log2(IMEM_DEPTH)
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     start        pulse: leave IDLE/HALTED and begin execution at PC 0
//     stall        hold PC, state and outputs while in RUN
//     imem_we      instruction memory write enable (honoured in IDLE only)
//     imem_waddr   instruction memory write address
//     imem_wdata   instruction memory write data
//     instrcode    instruction to IF/ID (8'h00 bubble outside RUN)
//     regwrite     pre-decoded register-write enable
//     wbsel        writeback select: 0 = ALU result, 1 = immediate
//     pc_out       current PC
//     running      high in RUN
//     halted       high in HALTED
//     fetch_count  instructions issued (optional feature)
//
//   Optional feature macro: INSTR_COUNT_EN
//     defined   : fetch_count counts unstalled RUN cycles (HALT included)
//     undefined : fetch_count is tied to 16'h0000
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [7:0]      imem_wdata,
  output logic [7:0]      instrcode,
  output logic            regwrite,
  output logic            wbsel,
  output logic [PC_W-1:0] pc_out,
  output logic            running,
  output logic            halted,
  output logic [15:0]     fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t          state, next_state;
  logic [PC_W-1:0] pc, next_pc;
  logic [7:0]      imem [IMEM_DEPTH];
  logic [7:0]      cur_instr;

  // Asynchronous read: the word at pc is visible in the same cycle.
  assign cur_instr = imem[pc];

  // Memory is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && imem_we && state == IDLE) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    instrcode  = 8'h00;
    regwrite   = 1'b0;
    wbsel      = 1'b0;

    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          next_state = RUN;
          next_pc    = '0;
        end
      end

      RUN: begin
        instrcode = cur_instr;
        regwrite  = (cur_instr[7:6] == OP_ADD) || (cur_instr[7:6] == OP_LDI);
        wbsel     = (cur_instr[7:6] == OP_LDI);
        // Stall takes precedence over every PC/state change.
        if (!stall) begin
          unique case (cur_instr[7:6])
            OP_ADD, OP_LDI: next_pc = pc + PC_W'(1);
            // Low PC_W bits of the 6-bit target give the modulo-depth wrap.
            OP_JMP:         next_pc = cur_instr[PC_W-1:0];
            OP_HALT:        next_state = HALTED;
            default:        next_pc = pc;
          endcase
        end
      end

      default: begin
        next_state = IDLE;
        next_pc    = '0;
      end
    endcase
  end

  assign pc_out  = pc;
  assign running = (state == RUN);
  assign halted  = (state == HALTED);

`ifdef INSTR_COUNT_EN
  logic [15:0] fetch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
    end else if (state == RUN && !stall) begin
      fetch_cnt <= fetch_cnt + 16'h0001;
    end
  end

  assign fetch_count = fetch_cnt;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Scoreboard bench for instr_fetch. The driver applies one cycle of inputs,
//   advances a behavioural reference model over the same edge and pushes the
//   expected outputs into a queue; an independent monitor pops one entry per
//   cycle on the falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DEPTH = 64;
  localparam int PW    = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          imem_we;
  logic [PW-1:0] imem_waddr;
  logic [7:0]    imem_wdata;
  logic [7:0]    instrcode;
  logic          regwrite;
  logic          wbsel;
  logic [PW-1:0] pc_out;
  logic          running;
  logic          halted;
  logic [15:0]   fetch_count;

  instr_fetch #(.IMEM_DEPTH(DEPTH), .PC_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .instrcode  (instrcode),
    .regwrite   (regwrite),
    .wbsel      (wbsel),
    .pc_out     (pc_out),
    .running    (running),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  instr;
    logic        rw;
    logic        ws;
    logic [5:0]  pc;
    logic        run;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: mode 0 = idle, 1 = executing, 2 = stopped.
  logic [7:0]  m_mem [DEPTH];
  int          m_mode  = 0;
  int          m_pc    = 0;
  logic [15:0] m_count = 16'h0000;

  task automatic modelEdge(input logic r, input logic s, input logic st,
                           input logic we, input logic [5:0] wa,
                           input logic [7:0] wd);
    logic [7:0] w;
    if (r) begin
      m_mode  = 0;
      m_pc    = 0;
      m_count = 16'h0000;
    end else if (m_mode == 1) begin
      if (!st) begin
        w = m_mem[m_pc];
        m_count = m_count + 16'd1;
        if (w[7:6] == 2'b00 || w[7:6] == 2'b01) m_pc = (m_pc + 1) % DEPTH;
        else if (w[7:6] == 2'b10) m_pc = (int'(w) % 64) % DEPTH;
        else m_mode = 2;
      end
    end else begin
      if (m_mode == 0 && we) m_mem[int'(wa) % DEPTH] = wd;
      if (s) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    logic [7:0] w;
    w     = m_mem[m_pc];
    e.instr = (m_mode == 1) ? w : 8'h00;
    e.rw    = (m_mode == 1) && (w[7:6] == 2'b00 || w[7:6] == 2'b01);
    e.ws    = (m_mode == 1) && (w[7:6] == 2'b01);
    e.pc    = 6'(m_pc);
    e.run   = (m_mode == 1);
    e.hlt   = (m_mode == 2);
`ifdef INSTR_COUNT_EN
    e.cnt   = m_count;
`else
    e.cnt   = 16'h0000;
`endif
    return e;
  endfunction

  // One clock of stimulus, then the model follows the same edge.
  task automatic applyStimulus(input logic r, input logic s, input logic st,
                               input logic we, input logic [5:0] wa,
                               input logic [7:0] wd);
    rst        = r;
    start      = s;
    stall      = st;
    imem_we    = we;
    imem_waddr = wa;
    imem_wdata = wd;
    @(posedge clk);
    #1;
    modelEdge(r, s, st, we, wa, wd);
    sbq.push_back(modelOutputs());
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic writeMem(input logic [5:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic checkField(input string name, input logic [15:0] act,
                            input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("instrcode",   16'(instrcode),   16'(e.instr));
    checkField("regwrite",    16'(regwrite),    16'(e.rw));
    checkField("wbsel",       16'(wbsel),       16'(e.ws));
    checkField("pc_out",      16'(pc_out),      16'(e.pc));
    checkField("running",     16'(running),     16'(e.run));
    checkField("halted",      16'(halted),      16'(e.hlt));
    checkField("fetch_count", fetch_count,      e.cnt);
  endtask

  // Monitor: one expected entry per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hC0;

    // Fill memory with HALTs so nothing unknown is ever fetched.
    doReset();
    doReset();
    for (int i = 0; i < DEPTH; i++) writeMem(6'(i), 8'hC0);

    // ADD, LDI, JMP 31, HALT; jump lands on a HALT at 31.
    writeMem(6'd0, 8'h0A);
    writeMem(6'd1, 8'h4D);
    writeMem(6'd2, 8'h9F);
    writeMem(6'd3, 8'hC0);
    pulseStart();
    idleCycles(6);

    // ADD x5 then HALT at 5; restart from HALTED; stall is ignored in HALTED.
    doReset();
    for (int i = 0; i < 5; i++) writeMem(6'(i), 8'(i * 9));
    writeMem(6'd5, 8'hC0);
    pulseStart();
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    pulseStart();
    idleCycles(3);

    // JMP at pc 2 under 3 stall cycles; start and stall together in IDLE.
    doReset();
    writeMem(6'd0, 8'h01);
    writeMem(6'd1, 8'h42);
    writeMem(6'd2, 8'hA8);
    writeMem(6'd40, 8'hC0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 8'h00);
    idleCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    idleCycles(3);

    // All ADDs, no HALT: PC wraps and the counter reaches 64 after 64 cycles.
    doReset();
    for (int i = 0; i < DEPTH; i++) writeMem(6'(i), 8'($urandom_range(0, 63)));
    pulseStart();
    idleCycles(70);

    // Mid-run reset at pc 10 with write attempts and start pulses during RUN.
    doReset();
    pulseStart();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'(i == 4), 1'b0, 1'b1, 6'($urandom_range(0, 63)), 8'hC0);
    doReset();
    idleCycles(2);
    pulseStart();
    idleCycles(66);

    // Randomised mix of all inputs over a random program.
    doReset();
    for (int i = 0; i < DEPTH; i++) writeMem(6'(i), 8'($urandom_range(0, 255)));
    pulseStart();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 2),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0),
                    6'($urandom_range(0, 63)),
                    8'($urandom_range(0, 255)));
    end
    idleCycles(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d entries left, required=0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
